// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multicycle MIPS core.
// Memory access sizes, memory-interface FSM states, reset vector.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } typeMemSize;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RCAP = 2'b10,
    DONE = 2'b11
  } typeMemIfState;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_cpu_lane_align.sv
// Byte-lane steering for sized loads/stores (combinational).
// In: size_i, sign_i, addr_i[1:0], wdata_i, rdata_i.
// Out: be_o, wdata_o (replicated), rdata_o (extended), misalign_o.
module mips_cpu_lane_align
  import mips_cpu_pkg::*;
(
  input  typeMemSize  size_i,
  input  logic        sign_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_lane = rdata_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = rdata_i;
    misalign_o = 1'b0;
    unique case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & byte_lane[7]}},
                   byte_lane};
      end
      SIZE_HALF: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{sign_i & half_lane[15]}},
                      half_lane};
        misalign_o = addr_i[0];
      end
      SIZE_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |addr_i;
      end
      SIZE_BAD: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_if.sv
// Memory-stage load/store unit bridging the core to an Avalon-MM master.
// Core: req_*, busy, rsp_done/err/rdata. Avalon: address, read, write, etc.
module mips_cpu_mem_if
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_RDATA = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_done,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typeMemIfState state_q, state_d;
  typeMemSize    size_q, size_d;
  logic          wr_l_q, wr_l_d;
  logic          sign_q, sign_d;
  logic [1:0]    alo_q, alo_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   wd_q, wd_d;
  logic [3:0]    be_q, be_d;

  logic          idle;
  typeMemSize    la_size;
  logic          la_sign;
  logic [1:0]    la_addr;
  logic [3:0]    la_be;
  logic [31:0]   la_wdata;
  logic [31:0]   la_rdata;
  logic          la_mis;

  // In IDLE the aligner looks at the live request so the
  // first bus cycle is ready on the accepting edge; later it
  // works from the latched copy for the load extract.
  assign idle    = (state_q == IDLE);
  assign la_size = idle ? typeMemSize'(req_size) : size_q;
  assign la_sign = idle ? req_signed : sign_q;
  assign la_addr = idle ? req_addr[1:0] : alo_q;

  mips_cpu_lane_align u_align (
    .size_i     (la_size),
    .sign_i     (la_sign),
    .addr_i     (la_addr),
    .wdata_i    (req_wdata),
    .rdata_i    (readdata),
    .be_o       (la_be),
    .wdata_o    (la_wdata),
    .rdata_o    (la_rdata),
    .misalign_o (la_mis)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    wr_l_d  = wr_l_q;
    sign_d  = sign_q;
    alo_d   = alo_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d = typeMemSize'(req_size);
          wr_l_d = req_write;
          sign_d = req_signed;
          alo_d  = req_addr[1:0];
          busy_d = 1'b1;
          if (la_mis) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = BUS;
            addr_d  = {req_addr[31:2], 2'b00};
            rd_d    = !req_write;
            wr_d    = req_write;
            be_d    = la_be;
            wd_d    = la_wdata;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (wr_l_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RCAP;
          end
        end
      end
      RCAP: begin
        rdata_d = la_rdata;
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= SIZE_BYTE;
      wr_l_q  <= 1'b0;
      sign_q  <= 1'b0;
      alo_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= RESET_RDATA;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      wr_l_q  <= wr_l_d;
      sign_q  <= sign_d;
      alo_q   <= alo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
    end
  end

  assign busy       = busy_q;
  assign rsp_done   = done_q;
  assign rsp_err    = err_q;
  assign rsp_rdata  = rdata_q;
  assign address    = addr_q;
  assign read       = rd_q;
  assign write      = wr_q;
  assign writedata  = wd_q;
  assign byteenable = be_q;

endmodule

// File: tb/tb_mips_cpu_mem_if.sv
// Scoreboard bench for mips_cpu_mem_if with an Avalon slave model.
// Random and directed loads/stores against a byte-level reference model.
module tb_mips_cpu_mem_if;

  localparam logic [31:0] RST_RD = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  mips_cpu_mem_if #(.RESET_RDATA(RST_RD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .busy        (busy),
    .rsp_done    (rsp_done),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] lanes;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wcnt = 0;
  logic [31:0] cur_rd = '0;
  logic [31:0] model_rd = RST_RD;
  logic        rd_pend = 1'b0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  endtask

  // Avalon slave: inserts the requested wait states, checks
  // hold stability and each accepted transfer, and returns
  // readdata only in the cycle after the accepted read.
  logic        hold_v = 1'b0;
  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic [3:0]  s_be;
  logic        s_rd;
  logic        s_wr;
  bus_t        eb;
  logic [31:0] mask;

  always @(negedge clk) begin
    readdata = rd_pend ? cur_rd : $urandom;
    rd_pend  = 1'b0;
    if (read || write) begin
      if (hold_v) begin
        chk("hold_addr", address, s_addr);
        chk("hold_rw", {read, write}, {s_rd, s_wr});
        chk("hold_be", byteenable, s_be);
        chk("hold_wd", writedata, s_wd);
      end
      if (wcnt > 0) begin
        waitrequest = 1'b1;
        wcnt--;
        hold_v = 1'b1;
        s_addr = address;
        s_wd   = writedata;
        s_be   = byteenable;
        s_rd   = read;
        s_wr   = write;
      end else begin
        waitrequest = 1'b0;
        hold_v = 1'b0;
        if (bus_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_bus: got rw=%b%b expected none",
                   read, write);
        end else begin
          eb = bus_q.pop_front();
          chk("bus_addr", address, eb.addr);
          chk("bus_rw", {read, write}, {!eb.wr, eb.wr});
          chk("bus_be", byteenable, eb.be);
          if (eb.wr) begin
            mask = '0;
            for (int i = 0; i < 4; i++)
              if (eb.be[i]) mask[i*8 +: 8] = 8'hFF;
            chk("bus_wdata", writedata & mask, eb.lanes);
          end
        end
        if (read) rd_pend = 1'b1;
      end
    end else begin
      hold_v = 1'b0;
      waitrequest = 1'($urandom_range(0, 1));
    end
  end

  // Response monitor.
  rsp_t er;
  always @(negedge clk) begin
    if (rsp_done) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        er = rsp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(er.err));
        chk("rsp_rdata", rsp_rdata, er.rdata);
        chk("rsp_cycle", cyc, er.due);
      end
    end
  end

  task automatic garbage();
    req_valid  = 1'($urandom_range(0, 1));
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Issue one request at a negedge with busy low, after
  // pushing the reference expectations.
  task automatic issue(logic wr, logic [1:0] sz, logic sg,
                       logic [31:0] a, logic [31:0] wd,
                       logic [31:0] rdv, int nw);
    int t = 0;
    int nb;
    int off;
    int lat;
    logic bad;
    bus_t b;
    rsp_t r;
    logic [31:0] v;
    while (busy) begin
      garbage();
      @(negedge clk);
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL busy_timeout: got busy=1 expected 0");
        finish_now();
      end
    end
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    bad = (sz == 2'd3) || (a % nb != 0);
    if (!bad) begin
      b.addr  = a - (a % 4);
      b.wr    = wr;
      b.be    = '0;
      b.lanes = '0;
      for (int i = 0; i < nb; i++) begin
        b.be[off + i] = 1'b1;
        b.lanes[(off + i)*8 +: 8] = wd[i*8 +: 8];
      end
      bus_q.push_back(b);
      if (!wr) begin
        if (nb == 4) begin
          v = rdv;
        end else if (nb == 1) begin
          v = (rdv >> (8*off)) & 32'hFF;
          if (sg && v >= 128) v = v - 256;
        end else begin
          v = (rdv >> (8*off)) & 32'hFFFF;
          if (sg && v >= 32768) v = v - 65536;
        end
        model_rd = v;
      end
    end
    lat = bad ? 1 : (wr ? 2 + nw : 3 + nw);
    r.err   = bad;
    r.rdata = model_rd;
    r.due   = cyc + lat;
    rsp_q.push_back(r);
    wcnt       = nw;
    cur_rd     = rdv;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    garbage();
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || rsp_q.size() != 0) && t < 200) begin
      req_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    req_valid = 1'b0;
    chk("drain_rsp", rsp_q.size(), 0);
    chk("drain_bus", bus_q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_read", 32'(read), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(rsp_done), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_addr", address, 0);
    chk("rst_wd", writedata, 0);
    chk("rst_be", 32'(byteenable), 0);
    chk("rst_rdata", rsp_rdata, RST_RD);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    waitrequest = 1'b0;
    readdata    = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    issue(1, 2'd2, 0, 32'hBFC00010, 32'hDEADBEEF, 0, 0);
    drain();
    issue(0, 2'd0, 1, 32'h00001003, 0, 32'h80AABBCC, 0);
    issue(0, 2'd0, 0, 32'h00001003, 0, 32'h80AABBCC, 0);
    issue(0, 2'd1, 1, 32'h00001002, 0, 32'h80017FFF, 0);
    issue(0, 2'd1, 1, 32'h00001000, 0, 32'h80017FFF, 0);
    issue(0, 2'd2, 0, 32'h00002000, 0, 32'h13572468, 3);
    issue(1, 2'd1, 0, 32'h00001001, 32'h1234, 0, 0);
    issue(0, 2'd2, 0, 32'h00001002, 0, 32'hFFFFFFFF, 0);
    issue(1, 2'd3, 0, 32'h00001000, 32'h1, 0, 0);
    issue(1, 2'd0, 0, 32'h00003002, 32'h000000A5, 0, 1);
    issue(1, 2'd1, 0, 32'h00003002, 32'h0000BEEF, 0, 2);
    drain();

    // Abandon a stalled load with reset.
    issue(0, 2'd2, 0, 32'h00004000, 0, 32'hCAFEF00D, 30);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_read", 32'(read), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    bus_q.delete();
    rsp_q.delete();
    wcnt = 0;
    model_rd = RST_RD;
    @(negedge clk);
    issue(0, 2'd1, 0, 32'h00005002, 0, 32'hF00D1234, 0);
    drain();

    for (int k = 0; k < 300; k++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3
                                        : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), $urandom, $urandom,
            $urandom,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
    drain();

    finish_now();
  end

endmodule
